// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Brief    : Bitwise/compare logic unit with a valid/ready register pipeline
//            and a saturating completed-operation counter.
//            Optional macro LOGIC_ZERO_FLAG_EN adds the Logic_Zero output.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int STAGES         = 2,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [IN_DATA_WIDTH-1:0]  A,
  input  logic [IN_DATA_WIDTH-1:0]  B,
  input  logic [2:0]                ALU_FUNC,
  input  logic                      Logic_enable,
  output logic                      Logic_in_ready,
  output logic [OUT_DATA_WIDTH-1:0] Logic_OUT,
  output logic                      Logic_Flag,
  input  logic                      Logic_out_ready,
`ifdef LOGIC_ZERO_FLAG_EN
  output logic                      Logic_Zero,
`endif
  output logic [CNT_WIDTH-1:0]      Logic_Count
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  logic [IN_DATA_WIDTH-1:0]              w_res;
  logic [OUT_DATA_WIDTH-1:0]             w_res_ext;
  logic [STAGES-1:0]                     w_ready;
  logic                                  w_acc;
  logic                                  w_accept;
  logic                                  w_xfer;

  logic [STAGES-1:0]                     r_valid_q, r_valid_d;
  logic [STAGES-1:0][OUT_DATA_WIDTH-1:0] r_data_q,  r_data_d;
  logic [CNT_WIDTH-1:0]                  r_count_q, r_count_d;
`ifdef LOGIC_ZERO_FLAG_EN
  logic [STAGES-1:0]                     r_zero_q,  r_zero_d;
`endif

  always_comb begin
    w_res = '0;
    case (ALU_FUNC)
      3'b000:  w_res = A & B;
      3'b001:  w_res = A | B;
      3'b010:  w_res = ~(A & B);
      3'b011:  w_res = ~(A | B);
      3'b100:  w_res = A ^ B;
      3'b101:  w_res = ~(A ^ B);
      3'b110:  w_res[0] = (A == B);
      default: w_res = ~A;
    endcase
    w_res_ext = OUT_DATA_WIDTH'(w_res);
  end

  // A stage can load if it is empty or anything downstream of it can move.
  always_comb begin
    w_acc = Logic_out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_acc      = w_acc | ~r_valid_q[k];
      w_ready[k] = w_acc;
    end
  end

  assign w_accept = Logic_enable & w_ready[0];
  assign w_xfer   = r_valid_q[STAGES-1] & Logic_out_ready;

  always_comb begin
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
`ifdef LOGIC_ZERO_FLAG_EN
    r_zero_d  = r_zero_q;
`endif
    if (w_ready[0]) begin
      r_valid_d[0] = w_accept;
      r_data_d[0]  = w_accept ? w_res_ext : '0;
`ifdef LOGIC_ZERO_FLAG_EN
      r_zero_d[0]  = w_accept & (w_res == '0);
`endif
    end
    for (int k = 1; k < STAGES; k++) begin
      if (w_ready[k]) begin
        r_valid_d[k] = r_valid_q[k-1];
        r_data_d[k]  = r_valid_q[k-1] ? r_data_q[k-1] : '0;
`ifdef LOGIC_ZERO_FLAG_EN
        r_zero_d[k]  = r_valid_q[k-1] & r_zero_q[k-1];
`endif
      end
    end
    r_count_d = (w_xfer && (r_count_q != c_CNT_MAX)) ? r_count_q + c_CNT_ONE : r_count_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
      r_count_q <= '0;
`ifdef LOGIC_ZERO_FLAG_EN
      r_zero_q  <= '0;
`endif
    end else begin
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_count_q <= r_count_d;
`ifdef LOGIC_ZERO_FLAG_EN
      r_zero_q  <= r_zero_d;
`endif
    end
  end

  assign Logic_in_ready = w_ready[0];
  assign Logic_OUT      = r_data_q[STAGES-1];
  assign Logic_Flag     = r_valid_q[STAGES-1];
  assign Logic_Count    = r_count_q;
`ifdef LOGIC_ZERO_FLAG_EN
  assign Logic_Zero     = r_zero_q[STAGES-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Brief    : Scoreboard bench for logic_unit_pipe (default parameters);
//            checks Logic_Zero when LOGIC_ZERO_FLAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

  localparam int c_STAGES = 2;
  localparam int c_CNT_MAX = 255;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] A, B;
  logic [2:0]  ALU_FUNC;
  logic        Logic_enable;
  logic        Logic_in_ready;
  logic [15:0] Logic_OUT;
  logic        Logic_Flag;
  logic        Logic_out_ready;
  logic [7:0]  Logic_Count;
`ifdef LOGIC_ZERO_FLAG_EN
  logic        Logic_Zero;
`endif

  logic_unit_pipe dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUNC(ALU_FUNC),
    .Logic_enable(Logic_enable), .Logic_in_ready(Logic_in_ready),
    .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
    .Logic_out_ready(Logic_out_ready),
`ifdef LOGIC_ZERO_FLAG_EN
    .Logic_Zero(Logic_Zero),
`endif
    .Logic_Count(Logic_Count)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [15:0] res; int cyc; } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cnt_exp = 0;
  int total_xfers = 0;
  bit strict_lat = 0;
  bit rand_done = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a & b);
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return (a == b) ? 16'd1 : 16'd0;
      default: return ~a;
    endcase
  endfunction

  // Offer one op (called at posedge+1) and hold it until accepted.
  task automatic send(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
    int waited = 0;
    bit done = 0;
    Logic_enable = 1'b1; ALU_FUNC = f; A = a; B = b;
    while (!done) begin
      @(negedge CLK);
      if (Logic_in_ready && !RST) begin
        sb.push_back('{res: ref_op(f, a, b), cyc: cyc});
        done = 1;
      end
      @(posedge CLK); #1;
      waited++;
      if (!done && waited > 100) begin
        chk("accept_timeout", 32'd0, 32'd1);
        done = 1;
      end
    end
    Logic_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
  endtask

  // Monitor: compares the pipeline head against the scoreboard every cycle.
  initial begin
    bit post_rst = 0;
    bit prev_stall = 0;
    logic [15:0] prev_out = '0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        sb.delete();
        cnt_exp = 0;
        total_xfers = 0;
        post_rst = 1;
        prev_stall = 0;
        continue;
      end
      if (post_rst) begin
        chk("rst_flag", Logic_Flag, 0);
        chk("rst_out", Logic_OUT, 0);
        chk("rst_in_ready", Logic_in_ready, 1);
        post_rst = 0;
      end
      chk("count", Logic_Count, cnt_exp);
      if (prev_stall) begin
        chk("stall_flag", Logic_Flag, 1);
        chk("stall_out", Logic_OUT, prev_out);
      end
      if (!Logic_Flag) begin
        chk("bubble_out", Logic_OUT, 0);
`ifdef LOGIC_ZERO_FLAG_EN
        chk("bubble_zero", Logic_Zero, 0);
`endif
      end else if (sb.size() == 0) begin
        chk("unexpected_output", Logic_Flag, 0);
      end else begin
        chk("data", Logic_OUT, sb[0].res);
`ifdef LOGIC_ZERO_FLAG_EN
        chk("zero_flag", Logic_Zero, (sb[0].res == 16'd0));
`endif
        if (Logic_out_ready) begin
          e = sb.pop_front();
          chk("latency_min", (cyc - e.cyc) >= c_STAGES, 1);
          if (strict_lat) chk("latency", cyc - e.cyc, c_STAGES);
          total_xfers++;
          if (cnt_exp < c_CNT_MAX) cnt_exp++;
        end
      end
      prev_stall = Logic_Flag && !Logic_out_ready;
      prev_out = Logic_OUT;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; Logic_enable = 1'b1; A = 16'h1111; B = 16'h1111;
    ALU_FUNC = 3'd0; Logic_out_ready = 1'b1;
    idle(2);
    RST = 1'b0; Logic_enable = 1'b0;
    idle(4);

    // Single AND with fixed latency
    strict_lat = 1;
    send(3'b000, 16'hF0F0, 16'hFF00);
    idle(4);
    chk("count_single", Logic_Count, 1);

    // Back-to-back ops, then the zero-result pair
    send(3'b100, 16'h00FF, 16'h0F0F);
    send(3'b101, 16'h00FF, 16'h0F0F);
    send(3'b110, 16'h1234, 16'h1234);
    send(3'b111, 16'h00FF, 16'h0000);
    send(3'b000, 16'h00FF, 16'hFF00);
    send(3'b001, 16'h00FF, 16'hFF00);
    idle(5);
    chk("count_b2b", Logic_Count, 7);
    strict_lat = 0;

    // Backpressure: two ops fill the pipe, the third stalls
    do_reset();
    Logic_out_ready = 1'b0;
    send(3'b001, 16'h1200, 16'h0034);
    send(3'b010, 16'hAAAA, 16'h0F0F);
    Logic_enable = 1'b1; ALU_FUNC = 3'b011; A = 16'h0101; B = 16'h1010;
    for (int i = 0; i < 3; i++) begin
      chk("full_in_ready", Logic_in_ready, 0);
      idle(1);
    end
    Logic_out_ready = 1'b1;
    send(3'b011, 16'h0101, 16'h1010);
    send(3'b100, 16'hFFFF, 16'h1234);
    idle(6);
    chk("count_bp", Logic_Count, 4);

    // Reset with ops in flight
    send(3'b000, 16'hFFFF, 16'hFFFF);
    send(3'b001, 16'h0000, 16'h5555);
    do_reset();
    idle(5);
    chk("count_mid_rst", Logic_Count, 0);

    // Random traffic with random backpressure, long enough to saturate
    fork
      begin
        for (int i = 0; i < 700; i++) begin
          logic [15:0] a, b;
          a = 16'($urandom);
          b = ($urandom_range(3) == 0) ? a : 16'($urandom);
          if ($urandom_range(3) == 0) idle(1);
          else send(3'($urandom_range(7)), a, b);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge CLK); #1;
          Logic_out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    Logic_out_ready = 1'b1;
    idle(8);
    chk("drain_empty", sb.size(), 0);
    chk("count_sat", Logic_Count, (total_xfers >= c_CNT_MAX) ? c_CNT_MAX : total_xfers);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
